// File: rtl/dmem_responder_if.sv
// Request/response bus between a requester and the dmem_responder data memory.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and
// ready are both 1; the sender keeps its payload stable while valid=1 and ready=0.
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding word memory responder: accepts one load/store, waits LAT cycles,
// performs the access and holds the response until the requester takes it.
module dmem_responder #(
    parameter int DEPTH = 128,
    parameter int LAT   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    dmem_responder_if.slave      bus,
    output logic [1:0]           dbg_state
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    logic          addr_err;
    logic [IW-1:0] idx;
    logic          access_now;

    assign addr_err   = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
    assign idx        = addr_q[IW+1:2];
    // The access happens on the same edge that leaves WAIT.
    assign access_now = (state == S_WAIT) && (cnt == 4'd1);

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.req_valid_i) state_nx = S_WAIT;
            S_WAIT: if (cnt == 4'd1) state_nx = S_RESP;
            S_RESP: if (bus.rsp_ready_i) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o = (state == S_IDLE);
        bus.rsp_valid_o = (state == S_RESP);
        bus.rsp_rdata_o = (state == S_RESP) ? rdata_q : 32'h0;
        bus.rsp_err_o   = (state == S_RESP) ? err_q : 1'b0;
        dbg_state       = state;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (state == S_IDLE && bus.req_valid_i) begin
            cnt     <= 4'(LAT);
            we_q    <= bus.req_we_i;
            addr_q  <= bus.req_addr_i;
            wdata_q <= bus.req_wdata_i;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
            if (access_now) begin
                err_q   <= addr_err;
                rdata_q <= (!addr_err && !we_q) ? mem[idx] : 32'h0;
            end
        end else if (state == S_RESP && bus.rsp_ready_i) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end
    end

    // Storage clears on reset, so a store still pending in WAIT is simply lost.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else if (access_now && we_q && !addr_err) begin
            mem[idx] <= wdata_q;
        end
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 128, giving the number of 32-bit words of storage.
REQ-002 The block SHALL have parameter LAT, default 2, giving the wait cycles between request accept and response; legal range 1..15.
REQ-003 clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req_valid_i  input  1  the requester presents a request.
REQ-006 req_ready_o  output  1  the block can accept a request.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wdata_i  input  32  store data.
REQ-010 rsp_valid_o  output  1  a response is presented.
REQ-011 rsp_ready_i  input  1  the requester takes the response.
REQ-012 rsp_rdata_o  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err_o  output  1  the access was misaligned or out of range.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-015 In IDLE, req_ready_o SHALL be 1; in WAIT and RESP it SHALL be 0.
REQ-016 A request SHALL be accepted only in a cycle with req_valid_i=1 and req_ready_o=1.
REQ-017 On accept, the block SHALL latch we, addr and wdata, load the wait counter with LAT, and move to WAIT.
REQ-018 Request inputs SHALL be ignored outside the accept cycle.
REQ-019 In WAIT, the counter SHALL decrement each cycle; when it reaches 0, the FSM SHALL move to RESP on the same edge that performs the access.
REQ-020 Timing: for an accept in cycle t, rsp_valid_o SHALL first be 1 in cycle t+1+LAT; with LAT=2 that is t+3.
REQ-021 Word index SHALL be addr[31:2].
REQ-022 An error SHALL be flagged when addr[1:0]!=0 or the word index is >= DEPTH.
REQ-023 On error, rsp_err_o SHALL be 1, no write SHALL occur, and rsp_rdata_o SHALL be 0.
REQ-024 A legal store SHALL write wdata to the word on the WAIT->RESP edge; rsp_rdata_o SHALL be 0 and rsp_err_o 0.
REQ-025 A legal load SHALL capture the word into rsp_rdata_o on the WAIT->RESP edge; rsp_err_o SHALL be 0.
REQ-026 In RESP, rsp_valid_o SHALL be 1, and rsp_rdata_o and rsp_err_o SHALL stay stable until rsp_ready_i=1.
REQ-027 On a cycle in RESP with rsp_ready_i=1, the FSM SHALL return to IDLE; rsp_valid_o SHALL be 0 the next cycle.
REQ-028 Only one transaction SHALL be outstanding at a time; a new request cannot be accepted in the same cycle as a response handshake.
REQ-029 A load following a store to the same word SHALL return the stored value.
REQ-030 Outside RESP, rsp_valid_o SHALL be 0, rsp_rdata_o SHALL hold 0, and rsp_err_o SHALL hold 0.

Reset
REQ-031 While rst_n=0 at a clock edge, the FSM SHALL enter IDLE and the counter SHALL clear.
REQ-032 While rst_n=0 at a clock edge, every storage word SHALL clear to 0.
REQ-033 While rst_n=0 at a clock edge, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL be 0; req_ready_o SHALL be 1 from the first cycle after reset.
REQ-034 Reset asserted in WAIT SHALL discard the pending access, including an uncommitted store.
REQ-035 Reset asserted in RESP SHALL drop the response without waiting for rsp_ready_i.

Verification
REQ-036 Store then load: store 0xDEADBEEF to addr 0x10, then load addr 0x10 with LAT=2 -> rsp_valid_o rises exactly 3 cycles after each accept; the load returns 0xDEADBEEF with rsp_err_o=0.
REQ-037 Backpressure: hold rsp_ready_i=0 for 5 cycles on a load of addr 0x10 -> rsp_valid_o=1 and rsp_rdata_o stable throughout; req_ready_o=0 despite req_valid_i=1; IDLE follows the first cycle with rsp_ready_i=1.
REQ-038 Errors: store to 0x13, then store to 4*DEPTH (0x200), then load 0x10 -> the two stores return rsp_err_o=1 and rdata 0; word 4 is unchanged.
REQ-039 Reset mid-WAIT: store 0x12345678 to 0x20, assert rst_n=0 one cycle after accept; after release load 0x20 -> returns 0; req_ready_o=1 in the first cycle after reset.
REQ-040 Back-to-back traffic: 8 alternating store/load pairs to words 0..7 with random rsp_ready_i delays -> every load matches its store, and no accept occurs while rsp_valid_o=1.
